store_write_buffer: RTL and testbench

Posted-write buffer between the MEM stage's cache controller and the SRAM controller; it is the sole master of the SRAM controller request port. Stores from the MEM stage retire into a small FIFO in one cycle and drain to SRAM in the background. Loads are forwarded from the buffer on an address hit; on a miss they are issued to SRAM only after all older stores have drained. This keeps the pipeline freeze (ready low) off the store path except when the buffer is full.

---
 rtl/swb_pkg.sv | 13 +
 rtl/swb_fifo.sv | 54 +++++
 rtl/store_write_buffer.sv | 79 +++++++
 tb/tb_store_write_buffer.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/swb_pkg.sv
// swb_pkg: shared types and widths for the store write buffer.
package swb_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int WORD_LSB = 2;

    typedef enum logic [1:0] {IDLE, DRAIN, READ} state_t;

    typedef struct packed {
        logic [ADDR_W-1:WORD_LSB] addr;
        logic [DATA_W-1:0]        data;
    } entry_t;
endpackage

// File: rtl/swb_fifo.sv
// swb_fifo: circular store queue with a youngest-match address search port.
module swb_fifo
    import swb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  entry_t                   pushEntry,
    input  logic                     pop,
    output entry_t                   headEntry,
    input  logic [ADDR_W-1:WORD_LSB] searchAddr,
    output logic                     hit,
    output logic [DATA_W-1:0]        hitData,
    output logic                     empty,
    output logic                     full
);
    localparam int PW = $clog2(DEPTH);

    entry_t mem [DEPTH];
    logic [PW-1:0] head, tail;
    logic [PW:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head <= '0;
            tail <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop) head <= head + PW'(1);
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge clk)
        if (push) mem[tail] <= pushEntry;

    // Walk oldest to youngest so the last match wins.
    always_comb begin
        hit = 1'b0;
        hitData = '0;
        for (int i = 0; i < DEPTH; i++)
            if ((PW+1)'(i) < count && mem[head + PW'(i)].addr == searchAddr) begin
                hit = 1'b1;
                hitData = mem[head + PW'(i)].data;
            end
    end

    assign headEntry = mem[head];
    assign empty = count == '0;
    assign full = count == (PW+1)'(DEPTH);
endmodule

// File: rtl/store_write_buffer.sv
// store_write_buffer: posted-write buffer that owns the SRAM request port,
// forwarding load hits and ordering load misses behind buffered stores.
module store_write_buffer
    import swb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_wr,
    input  logic              req_rd,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              sram_wr_en,
    output logic              sram_rd_en,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    input  logic              sram_ready,
    output logic              empty,
    output logic              full
);
    state_t state, nextState;
    entry_t headEntry, pushEntry;
    logic [ADDR_W-1:0] wordAddr;
    logic [DATA_W-1:0] hitData;
    logic hit, isLoad, readDone, push;

    assign wordAddr = req_addr & ~ADDR_W'((1 << WORD_LSB) - 1);
    assign isLoad = req_rd && !req_wr;
    assign readDone = state == READ && sram_ready;
    assign push = req_wr && !full;
    assign pushEntry = '{addr: wordAddr[ADDR_W-1:WORD_LSB], data: req_wdata};

    swb_fifo #(.DEPTH(DEPTH)) fifo (
        .clk(clk),
        .rst(rst),
        .push(push),
        .pushEntry(pushEntry),
        .pop(state == DRAIN && sram_ready),
        .headEntry(headEntry),
        .searchAddr(wordAddr[ADDR_W-1:WORD_LSB]),
        .hit(hit),
        .hitData(hitData),
        .empty(empty),
        .full(full)
    );

    // Every transaction returns through IDLE, giving the one-cycle turnaround.
    always_comb begin
        nextState = state;
        nextState = state == IDLE ? (!empty ? DRAIN : (isLoad && !hit) ? READ : IDLE)
                  : sram_ready ? IDLE : state;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            sram_wr_en <= 1'b0;
            sram_rd_en <= 1'b0;
            sram_addr <= '0;
            sram_wdata <= '0;
        end else begin
            state <= nextState;
            sram_wr_en <= nextState == DRAIN;
            sram_rd_en <= nextState == READ;
            if (state == IDLE && nextState == DRAIN) begin
                sram_addr <= {headEntry.addr, {WORD_LSB{1'b0}}};
                sram_wdata <= headEntry.data;
            end else if (state == IDLE && nextState == READ)
                sram_addr <= wordAddr;
        end
    end

    assign req_ready = req_wr ? !full : isLoad && (hit || readDone);
    assign rd_data = !isLoad ? '0 : hit ? hitData : readDone ? sram_rdata : '0;
endmodule

// File: tb/tb_store_write_buffer.sv
// tb_store_write_buffer: random and directed stimulus against a queue/memory model.
module tb_store_write_buffer;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic req_wr = 1'b0, req_rd = 1'b0, sram_ready = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0, sram_rdata = '0;
    logic req_ready, sram_wr_en, sram_rd_en, empty, full;
    logic [31:0] rd_data, sram_addr, sram_wdata;

    store_write_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_wr(req_wr), .req_rd(req_rd), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rd_data(rd_data),
        .sram_wr_en(sram_wr_en), .sram_rd_en(sram_rd_en),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata), .sram_ready(sram_ready),
        .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    typedef struct { logic [29:0] w; logic [31:0] d; } st_t;
    st_t pend[$];
    st_t wlog[$];
    logic [31:0] sramMem [logic [29:0]];
    logic [31:0] arch [logic [29:0]];

    int errs = 0, checks = 0, cyc = 0;
    bit accepted;
    logic [31:0] accData;
    int acceptCyc = -1, lastWrReadyCyc = -1, rdStartCyc = -1, rdReadyCyc = -1;
    bit prevWr, prevRd, prevReady;
    logic [31:0] prevAddr, prevData;
    bit busy, spurious;
    int cnt, fixLat = -1, wrEnCycles = 0;

    function automatic logic [31:0] initVal(input logic [29:0] w);
        return {2'b10, w} ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] sramGet(input logic [29:0] w);
        return sramMem.exists(w) ? sramMem[w] : initVal(w);
    endfunction

    function automatic logic [31:0] archGet(input logic [29:0] w);
        return arch.exists(w) ? arch[w] : initVal(w);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
        end
    endtask

    // One clock: compare at negedge, update the model, then play the SRAM side after posedge.
    task automatic step();
        int n;
        bit hitExp;
        logic [29:0] w;
        @(negedge clk);
        n = pend.size();
        w = req_addr[31:2];
        accepted = 0;
        chk("empty", 32'(empty), 32'(n == 0));
        chk("full", 32'(full), 32'(n == DEPTH));
        chk("sram_excl", 32'(sram_wr_en & sram_rd_en), 0);
        if (prevWr && !prevReady) begin
            chk("wr_hold_en", 32'(sram_wr_en), 1);
            chk("wr_hold_addr", sram_addr, prevAddr);
            chk("wr_hold_data", sram_wdata, prevData);
        end
        if (prevRd && !prevReady) begin
            chk("rd_hold_en", 32'(sram_rd_en), 1);
            chk("rd_hold_addr", sram_addr, prevAddr);
        end
        if ((prevWr || prevRd) && prevReady) chk("en_drop", 32'(sram_wr_en | sram_rd_en), 0);
        if (sram_rd_en) begin
            chk("rd_only_empty_miss", 32'(n == 0 && req_rd && !req_wr), 1);
            chk("rd_addr", sram_addr, {w, 2'b00});
        end
        if (req_wr) chk("st_ready", 32'(req_ready), 32'(n < DEPTH));
        else if (req_rd) begin
            hitExp = 0;
            foreach (pend[i]) if (pend[i].w == w) hitExp = 1;
            if (hitExp || (sram_rd_en && sram_ready)) begin
                chk("ld_ready", 32'(req_ready), 1);
                chk("ld_data", rd_data, archGet(w));
            end else chk("ld_wait", 32'(req_ready), 0);
        end else chk("idle_ready", 32'(req_ready), 0);
        if (sram_wr_en && sram_ready) begin
            chk("drain_nonempty", 32'(n > 0), 1);
            if (n > 0) begin
                chk("drain_addr", sram_addr, {pend[0].w, 2'b00});
                chk("drain_data", sram_wdata, pend[0].d);
                sramMem[pend[0].w] = pend[0].d;
                void'(pend.pop_front());
            end
            wlog.push_back(st_t'{w: sram_addr[31:2], d: sram_wdata});
            lastWrReadyCyc = cyc;
        end
        if (sram_rd_en && !prevRd) rdStartCyc = cyc;
        if (sram_rd_en && sram_ready) rdReadyCyc = cyc;
        if (sram_wr_en) wrEnCycles++;
        if (req_wr && req_ready) begin
            pend.push_back(st_t'{w: w, d: req_wdata});
            arch[w] = req_wdata;
            accepted = 1;
            acceptCyc = cyc;
        end else if (req_rd && req_ready) begin
            accepted = 1;
            accData = rd_data;
            acceptCyc = cyc;
        end
        prevWr = sram_wr_en;
        prevRd = sram_rd_en;
        prevReady = sram_ready;
        prevAddr = sram_addr;
        prevData = sram_wdata;
        @(posedge clk);
        #1;
        cyc++;
        if (sram_wr_en || sram_rd_en) begin
            if (!busy) begin
                busy = 1;
                cnt = fixLat >= 0 ? fixLat : int'($urandom_range(0, 4));
            end
            if (cnt == 0) begin
                sram_ready = 1;
                busy = 0;
            end else begin
                cnt--;
                sram_ready = 0;
            end
        end else begin
            busy = 0;
            sram_ready = spurious && ($urandom_range(0, 7) == 0);
        end
        sram_rdata = sram_rd_en ? sramGet(sram_addr[31:2]) : $urandom;
    endtask

    task automatic issue(input logic wr, input logic rd, input logic [31:0] a,
                         input logic [31:0] d, output int waited);
        req_wr = wr;
        req_rd = rd;
        req_addr = a;
        req_wdata = d;
        waited = 0;
        while (1) begin
            step();
            if (accepted) break;
            waited++;
            if (waited > 300) begin
                chk("req_timeout", 32'(waited), 32'd300);
                break;
            end
        end
        req_wr = 0;
        req_rd = 0;
    endtask

    task automatic drain();
        int k = 0;
        while ((pend.size() != 0 || sram_wr_en) && k < 400) begin
            step();
            k++;
        end
        chk("drain_done", 32'(pend.size()), 0);
        step();
    endtask

    task automatic wrAt(input string name, input int i, input logic [31:0] a, input logic [31:0] d);
        if (i < wlog.size()) begin
            chk({name, "_addr"}, {wlog[i].w, 2'b00}, a);
            chk({name, "_data"}, wlog[i].d, d);
        end else chk({name, "_missing"}, 32'(wlog.size()), 32'(i + 1));
    endtask

    task automatic modelReset();
        pend.delete();
        arch = sramMem;
        busy = 0;
        sram_ready = 0;
        prevWr = 0;
        prevRd = 0;
        prevReady = 0;
        req_wr = 0;
        req_rd = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int wt, k, op;
        logic [31:0] a;
        spurious = 0;
        req_rd = 1;
        req_addr = 32'h300;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_wr_en", 32'(sram_wr_en), 0);
        chk("rst_rd_en", 32'(sram_rd_en), 0);
        chk("rst_addr", sram_addr, 0);
        chk("rst_wdata", sram_wdata, 0);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_rdata", rd_data, 0);
        modelReset();
        rst = 1;

        fixLat = 2;
        wlog.delete();
        issue(1, 0, 32'h400, 32'h11, wt);
        chk("A_st0_wait", 32'(wt), 0);
        issue(1, 0, 32'h404, 32'h22, wt);
        chk("A_st1_wait", 32'(wt), 0);
        drain();
        chk("A_nwr", 32'(wlog.size()), 2);
        wrAt("A_w0", 0, 32'h400, 32'h11);
        wrAt("A_w1", 1, 32'h404, 32'h22);
        chk("A_empty", 32'(empty), 1);

        fixLat = 10;
        wlog.delete();
        rdStartCyc = -1;
        issue(1, 0, 32'h500, 32'hA, wt);
        issue(1, 0, 32'h500, 32'hB, wt);
        issue(0, 1, 32'h502, 32'h0, wt);
        chk("B_hit_wait", 32'(wt), 0);
        chk("B_hit_data", accData, 32'hB);
        chk("B_no_rd", 32'(rdStartCyc), 32'(-1));
        drain();
        wrAt("B_w0", 0, 32'h500, 32'hA);
        wrAt("B_w1", 1, 32'h500, 32'hB);

        fixLat = 5;
        wlog.delete();
        for (int i = 0; i < 4; i++) begin
            issue(1, 0, 32'h700 + 32'(4 * i), 32'(i + 1), wt);
            chk("C_fill_wait", 32'(wt), 0);
        end
        req_wr = 1;
        req_addr = 32'h710;
        req_wdata = 32'h5;
        #1;
        chk("C_full", 32'(full), 1);
        chk("C_stall", 32'(req_ready), 0);
        issue(1, 0, 32'h710, 32'h5, wt);
        chk("C_waited", 32'(wt), 4);
        chk("C_accept_after_drain", 32'(acceptCyc), 32'(lastWrReadyCyc + 1));
        drain();
        for (int i = 0; i < 5; i++) wrAt("C_w", i, 32'h700 + 32'(4 * i), 32'(i + 1));

        fixLat = 3;
        wlog.delete();
        sramMem[30'h180] = 32'hDEAD;
        arch[30'h180] = 32'hDEAD;
        rdStartCyc = -1;
        for (int i = 0; i < 3; i++) issue(1, 0, 32'h800 + 32'(4 * i), 32'h81 + 32'(i), wt);
        issue(0, 1, 32'h600, 32'h0, wt);
        chk("D_rd_start", 32'(rdStartCyc), 32'(lastWrReadyCyc + 2));
        chk("D_data", accData, 32'hDEAD);
        chk("D_done_cycle", 32'(acceptCyc), 32'(rdReadyCyc));
        chk("D_latency", 32'(rdReadyCyc - rdStartCyc), 3);
        chk("D_nwr", 32'(wlog.size()), 3);
        step();

        fixLat = -1;
        wlog.delete();
        for (int i = 0; i < 10; i++) issue(1, 0, 32'h900 + 32'(4 * i), 32'h1000 + 32'(17 * i), wt);
        drain();
        for (int i = 0; i < 10; i++) wrAt("E_w", i, 32'h900 + 32'(4 * i), 32'h1000 + 32'(17 * i));

        fixLat = 20;
        wlog.delete();
        issue(1, 0, 32'hA00, 32'h1, wt);
        issue(1, 0, 32'hA04, 32'h2, wt);
        k = 0;
        while (!sram_wr_en && k < 10) begin
            step();
            k++;
        end
        chk("F_pre_wr", 32'(sram_wr_en), 1);
        #2 rst = 0;
        #1;
        chk("F_wr_en", 32'(sram_wr_en), 0);
        chk("F_empty", 32'(empty), 1);
        chk("F_full", 32'(full), 0);
        modelReset();
        @(posedge clk);
        #1;
        rst = 1;
        wrEnCycles = 0;
        repeat (30) step();
        chk("F_no_wr", 32'(wrEnCycles), 0);
        chk("F_nlog", 32'(wlog.size()), 0);

        fixLat = -1;
        spurious = 1;
        for (int r = 0; r < 200; r++) begin
            op = int'($urandom_range(0, 19));
            a = 32'h100 + (32'($urandom_range(0, 7)) << 2) + 32'($urandom_range(0, 3));
            if (op < 5) repeat ($urandom_range(1, 3)) step();
            else if (op < 12) issue(1, 0, a, $urandom, wt);
            else if (op < 19) issue(0, 1, a, 32'h0, wt);
            else issue(1, 1, a, $urandom, wt);
        end
        spurious = 0;
        drain();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
